// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter for the WISC-S15 unified single-ported memory.
// Shares one memory between the instruction-fetch port and the data port,
// runs one access at a time for MEM_LAT cycles, and freezes the memory
// interface after HALT once the outstanding work has drained.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 4,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  input  logic              halt,
  output logic              halted,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StBusyI  = 2'd1;
  localparam logic [1:0] StBusyD  = 2'd2;
  localparam logic [1:0] StHalted = 2'd3;

  // Counter loads with the full latency, so it equals Lat only in the mem_en cycle.
  localparam logic [3:0] Lat = 4'(MEM_LAT);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              last_d_q, last_d_d;
  logic              halt_pend_q, halt_pend_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;

  logic if_ok, d_ok, grant_d, grant_i, busy;

  // Qualify requests and pick the winner in IDLE.
  always_comb begin
    // A request whose done pulse is high belongs to the access just finished.
    if_ok   = if_req & ~if_done_q & ~halt_pend_q;
    d_ok    = d_req & ~d_done_q;
    grant_d = (state_q == StIdle) & d_ok & (~if_ok | ~last_d_q);
    grant_i = (state_q == StIdle) & if_ok & ~grant_d;
  end

  // Next-state, holding-register and completion logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d_d    = last_d_q;
    halt_pend_d = halt_pend_q | halt;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d  = StBusyD;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          we_d     = d_we;
          cnt_d    = Lat;
          last_d_d = 1'b1;
        end else if (grant_i) begin
          state_d  = StBusyI;
          addr_d   = if_addr;
          wdata_d  = '0;
          we_d     = 1'b0;
          cnt_d    = Lat;
          last_d_d = 1'b0;
        end else if (halt_pend_q) begin
          // Pending data work has drained; freeze until reset.
          state_d = StHalted;
        end
      end
      StBusyI, StBusyD: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
          if (state_q == StBusyI) begin
            if_rdata_d = mem_rdata;
            if_done_d  = 1'b1;
          end else begin
            if (!we_q) begin
              d_rdata_d = mem_rdata;
            end
            d_done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // State registers with asynchronous reset that drops any in-flight access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      halt_pend_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_d_q    <= last_d_d;
      halt_pend_q <= halt_pend_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
    end
  end

  // Memory interface is a pure function of state so reset clears it at once.
  always_comb begin
    busy      = (state_q == StBusyI) | (state_q == StBusyD);
    mem_en    = busy & (cnt_q == Lat);
    mem_we    = mem_en & we_q;
    mem_addr  = busy ? addr_q : '0;
    mem_wdata = busy ? wdata_q : '0;
    halted    = (state_q == StHalted);
    if_rdata  = if_rdata_q;
    if_done   = if_done_q;
    d_rdata   = d_rdata_q;
    d_done    = d_done_q;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences the single-ported unified memory of the 16-bit WISC-S15 core.
- Shares that memory between the instruction-fetch port and the data port. The data port serves LW/RET reads and SW/CALL writes, driven from MemRead/MemWrite.
- Honours HALT from control logic: drains the outstanding access, then freezes the memory interface until reset.

Parameters:
MEM_LAT, 4, cycles from the mem_en cycle to the read-data-valid cycle, inclusive (legal 1..15; 1 = combinational read)
ADDR_W, 16, address width
DATA_W, 16, data width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level, held until if_done
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetched word, valid in the if_done cycle, held until next fetch completes
if_done  out  1  one-cycle completion pulse
d_req  in  1  data request, level, held until d_done
d_we  in  1  1 = write (SW/CALL), 0 = read (LW/RET)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read word, valid in the d_done cycle, held until next data completion
d_done  out  1  one-cycle completion pulse
halt  in  1  HALT from control logic
halted  out  1  arbiter frozen
mem_en  out  1  memory access strobe
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (asynchronous, immediate): state IDLE, every output 0, counter 0, last_grant=I, halt_pend=0. Any in-flight access is dropped; mem_en/mem_we fall in the same cycle.
- States: IDLE, BUSY_I, BUSY_D, HALTED.
- Arbitration in IDLE:
  - Only d_req: grant D.
  - Only if_req: grant I.
  - Both: grant I if last_grant==D, else grant D.
  - halt_pend masks if_req.
  - A port whose done is high this cycle has its req ignored.
- Grant edge:
  - Register addr/wdata/we into holding regs.
  - Load counter with MEM_LAT.
  - Update last_grant.
  - Enter BUSY_x.
- BUSY_x:
  - First cycle: mem_en=1, mem_we=held we (always 0 for I).
  - mem_addr and mem_wdata are driven from the holding regs for the whole BUSY period; they are 0 in IDLE/HALTED.
  - mem_we is high only in the mem_en cycle.
  - Counter decrements each cycle. In the cycle with counter==1, mem_rdata is sampled into x_rdata and the state returns to IDLE.
  - x_done pulses in the following cycle (registered). Writes also pulse done; d_rdata is unchanged on a write.
- Timing, MEM_LAT=4, request first seen in cycle 0:
  - mem_en in cycle 1.
  - Data sampled end of cycle 4.
  - done in cycle 5.
  - Next grant may be issued in cycle 5.
  - Per-access period is MEM_LAT+1 cycles.
- halt:
  - Any cycle with halt=1 sets sticky halt_pend.
  - An in-flight access completes normally. A pending d_req is still granted.
  - When IDLE, halt_pend=1 and no d_req, enter HALTED.
  - HALTED: halted=1, no grants, mem_en=0. Only rst_n exits.
- Requests dropped before done: the in-flight access still completes and done still pulses.

Test Plan:
- Reset: rst_n=0 with if_req=1, d_req=1 -> all outputs 0; after release, first grant is D.
- Single fetch, MEM_LAT=4: if_req, if_addr=0x0010, memory model returns 0xB123 -> mem_en=1/mem_we=0/mem_addr=0x0010 in cycle 1; if_done=1 and if_rdata=0xB123 in cycle 5 only.
- SW write: d_req, d_we=1, d_addr=0x0200, d_wdata=0xBEEF -> mem_en=mem_we=1 for exactly one cycle, mem_wdata=0xBEEF; d_done in cycle 5; model read-back of 0x0200 returns 0xBEEF.
- Contention: both req held continuously from reset -> grants D,I,D,I with mem_en in cycles 1,6,11,16; no port is starved.
- Halt: halt pulsed during a fetch while d_req (LW 0x0300) is pending -> fetch completes, LW completes; halted=1 thereafter; if_req held 20 cycles gives mem_en=0 throughout.
- Reset mid-access: rst_n low in cycle 2 of a fetch -> mem_en, if_done and mem_addr go 0 immediately; no done pulse; a fresh fetch after release completes in MEM_LAT+1 cycles.
